// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: segment patterns,
// digit-select encodings and the receive-side frame state machine states.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] SEL_BLANK = 2'b00;
    localparam logic [1:0] SEL_ONES  = 2'b01;
    localparam logic [1:0] SEL_TENS  = 2'b10;
    localparam logic [1:0] SEL_BAD   = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HALF0,
        ST_HALF1,
        ST_EMIT
    } frame_state_t;

    // Two BCD digits to binary; both digits are 0..9 so 7 bits always suffice.
    function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/seg_mux_decoder_if.sv
// Multiplexed seven-segment bus plus the decoded-value outputs of the monitor.
// master = display driver side, slave = decoder side.
interface seg_mux_decoder_if;
    logic [6:0] seg;
    logic [1:0] digit_select;
    logic [6:0] value;
    logic       value_valid;
    logic       seg_err;
    logic       stale;
    logic [7:0] err_count;

    modport master (
        output seg, digit_select,
        input  value, value_valid, seg_err, stale, err_count
    );

    modport slave (
        input  seg, digit_select,
        output value, value_valid, seg_err, stale, err_count
    );
endinterface

// File: rtl/seg_to_digit.sv
// Combinational inverse of the segment encoder: pattern -> {valid, BCD digit}.
module seg_to_digit
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        digit = 4'd0;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_mux_decoder.sv
// Receive-side monitor for the two-digit multiplexed seven-segment bus.
// Optional saturating error counter: define SEG_MUX_DECODER_ERRCNT_EN.
module seg_mux_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    seg_mux_decoder_if.slave  bus
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYC);
    localparam logic [SW-1:0] STAB_FIRE = SW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TMO       = TW'(TIMEOUT_CYC);

    logic [6:0]    seg_q;
    logic [1:0]    sel_q;
    logic [SW-1:0] stab_reg;
    frame_state_t  state_reg;
    logic [3:0]    d0_reg, d1_reg;
    logic          have0_reg, have1_reg;
    logic [6:0]    value_reg;
    logic          value_valid_reg, seg_err_reg;
    logic [TW-1:0] timer_reg;
    logic          stale_reg;

    logic          dig_valid;
    logic [3:0]    dig;

    seg_to_digit u_seg_to_digit (
        .seg   (seg_q),
        .valid (dig_valid),
        .digit (dig)
    );

    // A change is detected against the next registered value, so the sample
    // lands STABLE_CYC cycles after a pattern first appears on the pins.
    logic in_changed, sample, ones_ok, tens_ok, emit_go, err_go;
    assign in_changed = {bus.digit_select, bus.seg} != {sel_q, seg_q};
    assign sample     = (stab_reg == STAB_FIRE) && !in_changed;
    assign ones_ok    = sample && (sel_q == SEL_ONES) && dig_valid;
    assign tens_ok    = sample && (sel_q == SEL_TENS) && dig_valid;
    assign emit_go    = (state_reg != ST_EMIT) &&
                        ((ones_ok && have1_reg) || (tens_ok && have0_reg));
    assign err_go     = sample && ((sel_q == SEL_BAD) ||
                        (((sel_q == SEL_ONES) || (sel_q == SEL_TENS)) && !dig_valid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q           <= '0;
            sel_q           <= '0;
            stab_reg        <= '0;
            state_reg       <= ST_EMPTY;
            d0_reg          <= '0;
            d1_reg          <= '0;
            have0_reg       <= 1'b0;
            have1_reg       <= 1'b0;
            value_reg       <= '0;
            value_valid_reg <= 1'b0;
            seg_err_reg     <= 1'b0;
            timer_reg       <= '0;
            stale_reg       <= 1'b0;
        end else begin
            seg_q <= bus.seg;
            sel_q <= bus.digit_select;

            if (in_changed)
                stab_reg <= '0;
            else if (stab_reg != STAB_MAX)
                stab_reg <= stab_reg + 1'b1;

            seg_err_reg     <= err_go;
            value_valid_reg <= emit_go;
            if (emit_go)
                value_reg <= bcd2_to_bin(tens_ok ? dig : d1_reg, ones_ok ? dig : d0_reg);

            if (state_reg == ST_EMIT) begin
                state_reg <= ST_EMPTY;
                have0_reg <= 1'b0;
                have1_reg <= 1'b0;
            end else if (sample) begin
                case (sel_q)
                    SEL_ONES: begin
                        if (dig_valid) begin
                            d0_reg    <= dig;
                            have0_reg <= 1'b1;
                            state_reg <= emit_go ? ST_EMIT : ST_HALF0;
                        end else begin
                            have0_reg <= 1'b0;
                            if (state_reg == ST_HALF0)
                                state_reg <= ST_EMPTY;
                        end
                    end
                    SEL_TENS: begin
                        if (dig_valid) begin
                            d1_reg    <= dig;
                            have1_reg <= 1'b1;
                            state_reg <= emit_go ? ST_EMIT : ST_HALF1;
                        end else begin
                            have1_reg <= 1'b0;
                            if (state_reg == ST_HALF1)
                                state_reg <= ST_EMPTY;
                        end
                    end
                    SEL_BAD: begin
                        have0_reg <= 1'b0;
                        have1_reg <= 1'b0;
                        state_reg <= ST_EMPTY;
                    end
                    default: ;
                endcase
            end

            // EMIT takes priority over expiry so stale never rises with value_valid.
            if (emit_go) begin
                timer_reg <= '0;
                stale_reg <= 1'b0;
            end else if (timer_reg != TMO) begin
                timer_reg <= timer_reg + 1'b1;
                stale_reg <= (timer_reg + 1'b1) == TMO;
            end else begin
                stale_reg <= 1'b1;
            end
        end
    end

    assign bus.value       = value_reg;
    assign bus.value_valid = value_valid_reg;
    assign bus.seg_err     = seg_err_reg;
    assign bus.stale       = stale_reg;

`ifdef SEG_MUX_DECODER_ERRCNT_EN
    logic [7:0] err_count_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count_reg <= '0;
        else if (err_go && (err_count_reg != 8'hFF))
            err_count_reg <= err_count_reg + 1'b1;
    end
    assign bus.err_count = err_count_reg;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule

// File: doc/seg_mux_decoder.md
# seg_mux_decoder

Receive-side counterpart of the two-digit multiplexed seven-segment display driver. Samples the time-multiplexed `seg`/`digit_select` bus, rejects mux-transition glitches with a stability filter, and decodes each segment pattern back to a BCD digit. Reassembles the two-digit value (0..99) and emits it with a one-cycle valid strobe. Used as a loopback monitor and self-check on the display path and as the display-side monitor in system benches.

## Interface
- `STABLE_CYC`, 16: consecutive identical registered-input cycles before a digit is sampled; legal range ≥2.
- `TIMEOUT_CYC`, 65535: cycles without a completed frame before `stale` asserts.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `seg` in 7: segment pattern, active-high; bit0=a … bit6=g.
- `digit_select` in 2: 2'b01 = ones digit, 2'b10 = tens digit, 2'b00 = blank, 2'b11 = illegal.
- `value` out 7: last decoded value, 10*tens + ones. Reset 0.
- `value_valid` out 1: one-cycle strobe when `value` updates. Reset 0.
- `seg_err` out 1: one-cycle strobe on an undecodable pattern or illegal select. Reset 0.
- `stale` out 1: level; no frame completed within `TIMEOUT_CYC`. Reset 0.
- `err_count` out 8: saturating error count; see Configuration. Reset 0.

## Operation
- Input stage: `seg` and `digit_select` are registered once into `seg_q`/`sel_q`. Reset value 0.
- Stability counter `stab`, width `$clog2(STABLE_CYC+1)`:
  - Cleared to 0 when `{sel_q,seg_q}` differs from the previous cycle.
  - Otherwise increments and saturates at `STABLE_CYC`.
- Sample event: `stab == STABLE_CYC-1` and the input is unchanged. Fires exactly once per stable run.
- Decode map (hex pattern → digit): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9. Any other pattern is invalid.
- On a sample event, by `sel_q`:
  - 01: valid pattern → `d0` and `have0` set. Invalid → `seg_err` strobe, `have0` cleared.
  - 10: same behaviour, applied to `d1`/`have1`.
  - 00: ignored.
  - 11: `seg_err` strobe. `have0` and `have1` cleared.
- Frame FSM states:
  - EMPTY → HALF0 on valid ones digit; EMPTY → HALF1 on valid tens digit.
  - HALF0 + valid tens, or HALF1 + valid ones → EMIT.
  - Same digit again in a HALF state: overwrite the held digit, stay in state.
  - Error on the held digit position → EMPTY.
  - EMIT (one cycle): load `value` = `d1*10 + d0` (computed with a 7-bit result), pulse `value_valid`, clear `have*`, → EMPTY.
- Stale timer:
  - Counts up each cycle; cleared on EMIT.
  - On reaching `TIMEOUT_CYC` it holds and asserts `stale`.
  - `stale` deasserts in the cycle `value_valid` pulses.
- Reset mid-frame: all held digits, the FSM, and all timers return to their reset values asynchronously. `value` returns to 0.

## Timing
- Latency: a pattern first on the pins in cycle t produces its sample event in cycle t+STABLE_CYC.
- If that sample completes a frame, EMIT occurs, and `value`/`value_valid` are visible in cycle t+STABLE_CYC+1.
- `seg_err` is visible in cycle t+STABLE_CYC+1.
- Runs shorter than `STABLE_CYC` cycles are never sampled; these are mux transition glitches.
- Simultaneous EMIT and stale-timer expiry: EMIT wins. The timer clears and `stale` stays 0.
- The `seg_err` and `value_valid` strobes cannot coincide; each sample event produces one outcome.

## Configuration
- `SEG_MUX_DECODER_ERRCNT_EN` defined: `err_count` increments on every `seg_err` strobe and saturates at 255. Only reset clears it.
- Not defined: `err_count` is tied to 0 and no counter flops exist.

## Structure
- Shared package `seg_pkg`:
  - Segment-pattern constants `SEG_0`..`SEG_9` and `SEG_BLANK`.
  - Select encodings `SEL_ONES`, `SEL_TENS`.
  - The frame-FSM state enum.
- One sub-module `seg_to_digit`: combinational pattern → `{valid, digit[3:0]}`. It is the inverse of the encoder table. All sequential logic stays in `seg_mux_decoder`.

## Test plan
All scenarios use `STABLE_CYC`=4 and `TIMEOUT_CYC`=64.
- Clean frame: hold (01, 6D) for 6 cycles, then (10, 4F) for 6 cycles → one `value_valid` with `value`=35, 5 cycles after the tens pattern first appears.
- Glitch rejection: insert (10, 7F) for 2 cycles between stable digits of 42 → output 42; no 8 is ever captured; no `seg_err`.
- Invalid pattern: (01, 0x49) held for 6 cycles → one `seg_err`, no `value_valid`, FSM back to EMPTY; `err_count`=1 with the macro defined, 0 without.
- Boundaries: frames for 0 and 99 → `value`=0 and `value`=99; frame order tens-first (10, 06) then (01, 3F) → `value`=10.
- Stale: no input for 64 cycles → `stale`=1; a following valid frame → `stale`=0 in the same cycle as `value_valid`.
- Reset mid-frame: ones digit captured, then `rst` pulsed asynchronously → all outputs 0 immediately; the next tens digit alone produces no `value_valid`.
